// File: rtl/coef_bank_swap_pkg.sv
// coef_bank_pkg: shared swap-FSM state type and channel-field width helper for coef_bank_swap.
package coef_bank_pkg;
  typedef enum logic {IDLE, ARMED} swap_state_t;
  function automatic int chw(input int nch);
    return nch > 1 ? $clog2(nch) : 0;
  endfunction
endpackage

// File: rtl/coef_bank_swap_if.sv
// coef_bank_swap_if: host-side coefficient write/commit bus; readback signals exist only with COEF_READBACK_EN.
interface coef_bank_swap_if #(parameter int COEFW = 18, parameter int CW = 3, parameter int NCH = 4);
  localparam int AW = CW + coef_bank_pkg::chw(NCH);
  logic [COEFW-1:0] coef_write;
  logic [AW-1:0] coef_write_addr;
  logic coef_write_en;
  logic commit;
  logic active_bank;
  logic swap_pending;
  logic swap_done;
  logic write_err;
`ifdef COEF_READBACK_EN
  logic [AW-1:0] rb_addr;
  logic rb_req;
  logic [COEFW-1:0] rb_data;
  logic rb_valid;
`endif
  modport master(
    output coef_write, coef_write_addr, coef_write_en, commit,
`ifdef COEF_READBACK_EN
    output rb_addr, rb_req,
    input rb_data, rb_valid,
`endif
    input active_bank, swap_pending, swap_done, write_err
  );
  modport slave(
    input coef_write, coef_write_addr, coef_write_en, commit,
`ifdef COEF_READBACK_EN
    input rb_addr, rb_req,
    output rb_data, rb_valid,
`endif
    output active_bank, swap_pending, swap_done, write_err
  );
endinterface

// File: rtl/coef_bank_swap_ram.sv
// coef_bank_ram: one lane's two-bank store; registered address + registered output (2-cycle read), BRAM-shaped.
// With COEF_READBACK_EN the write port's address also drives a second 2-cycle read (adata).
module coef_bank_ram #(parameter int W = 18, parameter int AW = 4) (
  input  logic clk,
  input  logic rst,
  input  logic we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0] wdata,
  input  logic [AW-1:0] raddr,
`ifdef COEF_READBACK_EN
  output logic [W-1:0] adata,
`endif
  output logic [W-1:0] rdata
);
  logic [W-1:0] mem [2**AW];
  logic [AW-1:0] raddr_q;
`ifdef COEF_READBACK_EN
  logic [AW-1:0] aaddr_q;
  always_ff @(posedge clk) begin
    aaddr_q <= waddr;
    adata <= rst ? '0 : mem[aaddr_q];
  end
`endif
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    raddr_q <= raddr;
    rdata <= rst ? '0 : mem[raddr_q];
  end
endmodule

// File: rtl/shiftby.sv
// shiftby: WIDTH-bit delay line of BY register stages, cleared by rst.
module shiftby #(parameter int BY = 2, parameter int WIDTH = 3) (
  input  logic clk,
  input  logic rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] pipe [BY];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < BY; j++) pipe[j] <= '0;
    end else begin
      pipe[0] <= d;
      for (int j = 1; j < BY; j++) pipe[j] <= pipe[j-1];
    end
  end
  assign q = pipe[BY-1];
endmodule

// File: rtl/coef_bank_swap.sv
// coef_bank_swap: double-buffered NCH-lane FIR coefficient store; bank swap only at counter_in==0.
// Optional COEF_READBACK_EN adds a 2-cycle shadow-bank readback on the host bus.
module coef_bank_swap import coef_bank_pkg::*; #(
  parameter int COEFW = 18,
  parameter int CW = 3,
  parameter int NCH = 4,
  parameter int COUNT_SHIFT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic [CW-1:0] counter_in,
  output logic [CW-1:0] counter_out,
  output logic [NCH*COEFW-1:0] coef_out,
  coef_bank_swap_if.slave host
);
  localparam int CHW = chw(NCH);
  localparam int CHX = CHW > 0 ? CHW : 1;
  swap_state_t state, state_n;
  logic active_bank, zero, swap_now, rd_bank, wr_ok;
  logic [CHX-1:0] wr_lane;
  logic [CW-1:0] wr_row, a_row;
  logic [CW:0] a_addr;
`ifdef COEF_READBACK_EN
  logic [COEFW-1:0] a_data [NCH];
  logic [CHX-1:0] rb_lane, rb_lane1, rb_lane2;
  logic rb_v1;
`endif
  generate
    if (CHW > 0) begin : g_ch
      assign wr_lane = host.coef_write_addr[CW +: CHX];
`ifdef COEF_READBACK_EN
      assign rb_lane = host.rb_addr[CW +: CHX];
`endif
    end else begin : g_noch
      assign wr_lane = '0;
`ifdef COEF_READBACK_EN
      assign rb_lane = '0;
`endif
    end
  endgenerate
  assign wr_row = host.coef_write_addr[CW-1:0];
  always_comb begin
    zero = counter_in == '0;
    swap_now = state == ARMED && zero;
    // the swap cycle's row-0 read already comes from the incoming bank
    rd_bank = swap_now ? ~active_bank : active_bank;
    wr_ok = state == IDLE && host.coef_write_en;
    state_n = state == IDLE ? (host.commit ? ARMED : IDLE) : (zero ? IDLE : ARMED);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      active_bank <= 1'b0;
      host.swap_done <= 1'b0;
      host.write_err <= 1'b0;
    end else begin
      state <= state_n;
      active_bank <= active_bank ^ swap_now;
      host.swap_done <= swap_now;
      host.write_err <= state == IDLE ? host.write_err && !host.commit : host.write_err || host.coef_write_en;
    end
  end
  assign host.active_bank = active_bank;
  assign host.swap_pending = state == ARMED;
`ifdef COEF_READBACK_EN
  assign a_row = wr_ok ? wr_row : host.rb_addr[CW-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      rb_v1 <= 1'b0;
      host.rb_valid <= 1'b0;
      rb_lane1 <= '0;
      rb_lane2 <= '0;
    end else begin
      rb_v1 <= host.rb_req && !host.coef_write_en;
      host.rb_valid <= rb_v1;
      rb_lane1 <= rb_lane;
      rb_lane2 <= rb_lane1;
    end
  end
  assign host.rb_data = a_data[rb_lane2];
`else
  assign a_row = wr_row;
`endif
  assign a_addr = {~active_bank, a_row};
  for (genvar i = 0; i < NCH; i++) begin : g_lane
    coef_bank_ram #(.W(COEFW), .AW(CW + 1)) u_ram (
      .clk(clk),
      .rst(rst),
      .we(wr_ok && wr_lane == CHX'(i)),
      .waddr(a_addr),
      .wdata(host.coef_write),
      .raddr({rd_bank, counter_in}),
`ifdef COEF_READBACK_EN
      .adata(a_data[i]),
`endif
      .rdata(coef_out[i*COEFW +: COEFW])
    );
  end
  shiftby #(.BY(COUNT_SHIFT), .WIDTH(CW)) u_cnt (.clk(clk), .rst(rst), .d(counter_in), .q(counter_out));
endmodule

// File: tb/tb_coef_bank_swap.sv
// tb_coef_bank_swap: directed self-checking bench for coef_bank_swap (readback tests need COEF_READBACK_EN).
module tb_coef_bank_swap;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] counter_in = 3'd0;
  logic [2:0] counter_out;
  logic [71:0] coef_out;
  int tests = 0;
  int fails = 0;
  logic [17:0] m [2][4][8];
  logic [2:0] q0 = 3'd0, q1 = 3'd0;
  logic b0 = 1'b0, b1 = 1'b0;
  int vld = 0;

  coef_bank_swap_if #(.COEFW(18), .CW(3), .NCH(4)) bus();

  coef_bank_swap dut (
    .clk(clk),
    .rst(rst),
    .counter_in(counter_in),
    .counter_out(counter_out),
    .coef_out(coef_out),
    .host(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [17:0] pat(input int b, input int l, input int r);
    return 18'(b * 'h9000 + l * 'h900 + r * 'h47 + 3);
  endfunction

  function automatic logic [71:0] exp_coef(input logic b, input logic [2:0] r);
    logic [71:0] e;
    for (int l = 0; l < 4; l++) e[l*18 +: 18] = m[b][l][r];
    return e;
  endfunction

  // advance one clock; afterwards q1/b1 name the row/bank whose data is on coef_out
  task automatic cyc();
    logic [2:0] x;
    logic r;
    x = counter_in;
    r = rst;
    @(posedge clk);
    #1;
    q1 = q0;
    q0 = x;
    b1 = b0;
    b0 = bus.active_bank;
    vld = r ? 0 : vld + 1;
    counter_in = counter_in + 3'd1;
    bus.commit = 1'b0;
    bus.coef_write_en = 1'b0;
`ifdef COEF_READBACK_EN
    bus.rb_req = 1'b0;
`endif
  endtask

  task automatic wait_cin(input logic [2:0] c);
    for (int n = 0; n < 16 && counter_in != c; n++) cyc();
  endtask

  task automatic wait_swap(input string name);
    for (int n = 0; n < 12 && !bus.swap_done; n++) cyc();
    tests++;
    if (bus.swap_done !== 1'b1) begin
      fails++;
      $display("FAIL %s: swap_done never seen, got %b want 1", name, bus.swap_done);
    end
  endtask

  task automatic load_shadow(input int b);
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < 8; r++) begin
        bus.coef_write_addr = 5'(l * 8 + r);
        bus.coef_write = pat(b, l, r);
        bus.coef_write_en = 1'b1;
        m[b][l][r] = pat(b, l, r);
        cyc();
      end
    bus.commit = 1'b1;
    cyc();
    wait_swap("load_swap");
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc();
    cyc();
    tests++;
    if (counter_out !== 3'd0) begin fails++; $display("FAIL reset_counter_out: got %0d want 0", counter_out); end
    tests++;
    if (coef_out !== 72'd0) begin fails++; $display("FAIL reset_coef_out: got %h want 0", coef_out); end
    tests++;
    if ({bus.active_bank, bus.swap_pending, bus.swap_done, bus.write_err} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_flags: got %b want 0000", {bus.active_bank, bus.swap_pending, bus.swap_done, bus.write_err});
    end
`ifdef COEF_READBACK_EN
    tests++;
    if ({bus.rb_valid, bus.rb_data} !== 19'd0) begin fails++; $display("FAIL reset_rb: got %h want 0", {bus.rb_valid, bus.rb_data}); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_freerun();
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (vld >= 2) begin
        tests++;
        if (counter_out !== q1) begin fails++; $display("FAIL freerun_counter_out: got %0d want %0d", counter_out, q1); end
      end
      tests++;
      if ({bus.active_bank, bus.swap_pending, bus.swap_done, bus.write_err} !== 4'b0000) begin
        fails++;
        $display("FAIL freerun_flags: got %b want 0000", {bus.active_bank, bus.swap_pending, bus.swap_done, bus.write_err});
      end
    end
  endtask

  task automatic test_stream();
    load_shadow(1);
    load_shadow(0);
    tests++;
    if (bus.active_bank !== 1'b0) begin fails++; $display("FAIL stream_bank: got %b want 0", bus.active_bank); end
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (vld >= 2) begin
        tests++;
        if (coef_out !== exp_coef(b1, q1)) begin
          fails++;
          $display("FAIL stream_coef: row %0d got %h want %h", q1, coef_out, exp_coef(b1, q1));
        end
      end
    end
  endtask

  task automatic test_swap();
    bus.coef_write_addr = 5'b10101;
    bus.coef_write = 18'h1ABCD;
    bus.coef_write_en = 1'b1;
    m[1][2][5] = 18'h1ABCD;
    cyc();
    wait_cin(3'd3);
    bus.commit = 1'b1;
    cyc();
    tests++;
    if ({bus.swap_pending, bus.swap_done} !== 2'b10) begin fails++; $display("FAIL swap_armed: got %b want 10", {bus.swap_pending, bus.swap_done}); end
    for (int k = 0; k < 4; k++) begin
      cyc();
      tests++;
      if ({bus.swap_pending, bus.swap_done, bus.active_bank} !== 3'b100) begin
        fails++;
        $display("FAIL swap_wait: got %b want 100", {bus.swap_pending, bus.swap_done, bus.active_bank});
      end
    end
    cyc();
    tests++;
    if ({bus.swap_pending, bus.swap_done, bus.active_bank} !== 3'b011) begin
      fails++;
      $display("FAIL swap_edge: got %b want 011", {bus.swap_pending, bus.swap_done, bus.active_bank});
    end
    cyc();
    tests++;
    if (bus.swap_done !== 1'b0) begin fails++; $display("FAIL swap_done_pulse: got %b want 0", bus.swap_done); end
    tests++;
    if (counter_out !== 3'd0 || coef_out !== exp_coef(1'b1, 3'd0)) begin
      fails++;
      $display("FAIL swap_row0_new_bank: cnt %0d coef %h want cnt 0 coef %h", counter_out, coef_out, exp_coef(1'b1, 3'd0));
    end
    for (int n = 0; n < 16 && counter_out != 3'd5; n++) cyc();
    tests++;
    if (coef_out[36 +: 18] !== 18'h1ABCD) begin fails++; $display("FAIL swap_lane2_row5: got %h want 1abcd", coef_out[36 +: 18]); end
  endtask

  task automatic test_commit_zero();
    logic seen;
    seen = 1'b0;
    wait_cin(3'd0);
    bus.commit = 1'b1;
    cyc();
    tests++;
    if ({bus.swap_pending, bus.swap_done, bus.active_bank} !== 3'b101) begin
      fails++;
      $display("FAIL zero_commit: got %b want 101", {bus.swap_pending, bus.swap_done, bus.active_bank});
    end
    for (int k = 0; k < 7; k++) begin
      cyc();
      seen |= bus.swap_done;
    end
    tests++;
    if ({seen, bus.swap_pending} !== 2'b01) begin fails++; $display("FAIL zero_no_early_swap: got %b want 01", {seen, bus.swap_pending}); end
    cyc();
    tests++;
    if ({bus.swap_done, bus.active_bank} !== 2'b10) begin
      fails++;
      $display("FAIL zero_swap_next_frame: got %b want 10", {bus.swap_done, bus.active_bank});
    end
  endtask

  task automatic test_write_armed();
    wait_cin(3'd2);
    bus.commit = 1'b1;
    cyc();
    bus.coef_write_addr = 5'b10101;
    bus.coef_write = 18'h00777;
    bus.coef_write_en = 1'b1;
    cyc();
    tests++;
    if (bus.write_err !== 1'b1) begin fails++; $display("FAIL armed_write_err: got %b want 1", bus.write_err); end
    wait_swap("armed_swap");
    tests++;
    if ({bus.write_err, bus.active_bank} !== 2'b11) begin
      fails++;
      $display("FAIL armed_err_sticky: got %b want 11", {bus.write_err, bus.active_bank});
    end
    for (int n = 0; n < 16 && counter_out != 3'd5; n++) cyc();
    tests++;
    if (coef_out[36 +: 18] !== 18'h1ABCD) begin fails++; $display("FAIL armed_write_dropped: got %h want 1abcd", coef_out[36 +: 18]); end
    bus.commit = 1'b1;
    cyc();
    tests++;
    if ({bus.write_err, bus.swap_pending} !== 2'b01) begin
      fails++;
      $display("FAIL armed_err_clear: got %b want 01", {bus.write_err, bus.swap_pending});
    end
    wait_swap("armed_swap_back");
    tests++;
    if (bus.active_bank !== 1'b0) begin fails++; $display("FAIL armed_bank_back: got %b want 0", bus.active_bank); end
  endtask

  task automatic test_rst_armed();
    logic seen;
    seen = 1'b0;
    wait_cin(3'd4);
    bus.commit = 1'b1;
    cyc();
    cyc();
    tests++;
    if (bus.swap_pending !== 1'b1) begin fails++; $display("FAIL rst_pre_pending: got %b want 1", bus.swap_pending); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    tests++;
    if ({bus.swap_pending, bus.active_bank, bus.swap_done} !== 3'b000) begin
      fails++;
      $display("FAIL rst_armed_clear: got %b want 000", {bus.swap_pending, bus.active_bank, bus.swap_done});
    end
    for (int k = 0; k < 12; k++) begin
      cyc();
      seen |= bus.swap_done | bus.active_bank | bus.swap_pending;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL rst_no_swap_after: got %b want 0", seen); end
  endtask

`ifdef COEF_READBACK_EN
  task automatic test_readback();
    logic seen;
    seen = 1'b0;
    bus.rb_addr = 5'b10101;
    bus.rb_req = 1'b1;
    cyc();
    tests++;
    if (bus.rb_valid !== 1'b0) begin fails++; $display("FAIL rb_early: got %b want 0", bus.rb_valid); end
    cyc();
    tests++;
    if ({bus.rb_valid, bus.rb_data} !== {1'b1, 18'h1ABCD}) begin
      fails++;
      $display("FAIL rb_data: got %b/%h want 1/1abcd", bus.rb_valid, bus.rb_data);
    end
    cyc();
    tests++;
    if (bus.rb_valid !== 1'b0) begin fails++; $display("FAIL rb_pulse: got %b want 0", bus.rb_valid); end
    bus.rb_addr = 5'b00000;
    bus.rb_req = 1'b1;
    bus.coef_write_addr = 5'b00000;
    bus.coef_write = 18'h02468;
    bus.coef_write_en = 1'b1;
    m[1][0][0] = 18'h02468;
    for (int k = 0; k < 3; k++) begin
      cyc();
      seen |= bus.rb_valid;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL rb_write_wins: got %b want 0", seen); end
    bus.rb_req = 1'b1;
    cyc();
    cyc();
    tests++;
    if ({bus.rb_valid, bus.rb_data} !== {1'b1, 18'h02468}) begin
      fails++;
      $display("FAIL rb_after_write: got %b/%h want 1/02468", bus.rb_valid, bus.rb_data);
    end
  endtask
`endif

  initial begin
    bus.coef_write = '0;
    bus.coef_write_addr = '0;
    bus.coef_write_en = 1'b0;
    bus.commit = 1'b0;
`ifdef COEF_READBACK_EN
    bus.rb_addr = '0;
    bus.rb_req = 1'b0;
`endif
    test_reset();
    test_freerun();
    test_stream();
    test_swap();
    test_commit_zero();
    test_write_armed();
    test_rst_armed();
`ifdef COEF_READBACK_EN
    test_readback();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
